// File: rtl/painterengine_gpu_defs.sv
// Shared state codes, pixel-size encodings and latched frame configuration
// for the painterengine GPU frame reader.
package painterengine_gpu_defs;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CALC   = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_STREAM = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd7;

    // pixel_bytes is used directly as a left-shift amount (log2 of bytes per pixel)
    localparam logic [1:0] PB_1BYTE   = 2'd0;
    localparam logic [1:0] PB_2BYTE   = 2'd1;
    localparam logic [1:0] PB_4BYTE   = 2'd2;
    localparam logic [1:0] PB_ILLEGAL = 2'd3;

    typedef struct packed {
        logic [31:0] base;
        logic [15:0] stride;
        logic [15:0] width;
        logic [15:0] height;
        logic [1:0]  pixel_bytes;
        logic        continuous;
    } frame_cfg_t;

endpackage

// File: rtl/painterengine_gpu_frame_addrgen.sv
// Row base / column cursor and per-burst address and byte-length generation.
// Everything is shift-based; address arithmetic wraps modulo 2^32.
module painterengine_gpu_frame_addrgen #(
    parameter int PARAM_BLOCK_SIZE = 64
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [31:0] i_load_address,
    input  logic        i_advance,
    input  logic        i_next_row,
    input  logic [15:0] i_width,
    input  logic [15:0] i_stride,
    input  logic [1:0]  i_pixel_bytes,
    output logic [31:0] o_address,
    output logic [31:0] o_length,
    output logic        o_row_end
);

    localparam logic [15:0] BLOCK = 16'(PARAM_BLOCK_SIZE);

    logic [31:0] r_row_base;
    logic [15:0] r_x;
    logic [15:0] w_remain;
    logic [15:0] w_pixels;

    assign w_remain  = i_width - r_x;
    assign w_pixels  = (w_remain > BLOCK) ? BLOCK : w_remain;
    assign o_address = r_row_base + ({16'd0, r_x} << i_pixel_bytes);
    assign o_length  = {16'd0, w_pixels} << i_pixel_bytes;
    assign o_row_end = (r_x == i_width);

    // Load has priority so a continuous-mode frame wrap overrides the row step.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_row_base <= 32'd0;
            r_x        <= 16'd0;
        end else if (i_load) begin
            r_row_base <= i_load_address;
            r_x        <= 16'd0;
        end else if (i_next_row) begin
            r_row_base <= r_row_base + ({16'd0, i_stride} << i_pixel_bytes);
            r_x        <= 16'd0;
        end else if (i_advance) begin
            r_x        <= r_x + w_pixels;
        end
    end

endmodule

// File: rtl/painterengine_gpu_framereader.sv
// Frame reader sequencer: walks a clipped image in bursts of up to
// PARAM_BLOCK_SIZE pixels, gating each burst on FIFO space and reader status.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// CALC   | compute next burst address/length
// WAIT   | reader held in reset until FIFO has room
// STREAM | reader running one burst
// CHECK  | advance row / detect frame end
// DONE   | frame finished (or empty frame), waiting for start
// ERROR  | bus error seen, last burst held, waiting for start
module painterengine_gpu_framereader
    import painterengine_gpu_defs::*;
#(
    parameter int PARAM_BLOCK_SIZE  = 64,
    parameter int PARAM_LAUNCH_SIZE = 64,
    parameter int PARAM_COUNT_WIDTH = 8
) (
    input  logic                         i_wire_clock,
    input  logic                         i_wire_reset,
    input  logic                         i_wire_start,
    input  logic                         i_wire_continuous,
    input  logic [31:0]                  i_wire_image_address,
    input  logic [15:0]                  i_wire_image_stride,
    input  logic [15:0]                  i_wire_clip_width,
    input  logic [15:0]                  i_wire_clip_height,
    input  logic [1:0]                   i_wire_pixel_bytes,
    input  logic [PARAM_COUNT_WIDTH-1:0] i_wire_fifo_empty_count,
    output logic [31:0]                  o_wire_reader_address,
    output logic [31:0]                  o_wire_reader_length,
    output logic                         o_wire_reader_resetn,
    input  logic                         i_wire_reader_done,
    input  logic                         i_wire_reader_error,
    output logic                         o_wire_frame_done,
    output logic                         o_wire_busy,
    output logic [2:0]                   o_wire_state,
    output logic [15:0]                  o_wire_line
);

    logic [2:0]  r_state;
    frame_cfg_t  r_cfg;
    logic [31:0] r_address;
    logic [31:0] r_length;
    logic        r_frame_done;
    logic [15:0] r_line;

    logic        w_start_ok;
    logic        w_row_end;
    logic        w_last_row;
    logic        w_frame_end;
    logic        w_load;
    logic [31:0] w_load_address;
    logic        w_advance;
    logic        w_next_row;
    logic        w_fifo_ready;
    logic [31:0] w_address;
    logic [31:0] w_length;

    assign w_start_ok     = i_wire_start &&
                            (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERROR);
    assign w_last_row     = ((r_line + 16'd1) == r_cfg.height);
    assign w_frame_end    = (r_state == ST_CHECK) && w_row_end && w_last_row;
    assign w_load         = w_start_ok || (w_frame_end && r_cfg.continuous);
    assign w_load_address = w_start_ok ? i_wire_image_address : r_cfg.base;
    assign w_advance      = (r_state == ST_STREAM) && i_wire_reader_done && !i_wire_reader_error;
    assign w_next_row     = (r_state == ST_CHECK) && w_row_end;
    assign w_fifo_ready   = 32'(i_wire_fifo_empty_count) >= 32'(PARAM_LAUNCH_SIZE);

    painterengine_gpu_frame_addrgen #(
        .PARAM_BLOCK_SIZE (PARAM_BLOCK_SIZE)
    ) u_addrgen (
        .i_clock        (i_wire_clock),
        .i_reset        (i_wire_reset),
        .i_load         (w_load),
        .i_load_address (w_load_address),
        .i_advance      (w_advance),
        .i_next_row     (w_next_row),
        .i_width        (r_cfg.width),
        .i_stride       (r_cfg.stride),
        .i_pixel_bytes  (r_cfg.pixel_bytes),
        .o_address      (w_address),
        .o_length       (w_length),
        .o_row_end      (w_row_end)
    );

    always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
        if (i_wire_reset) begin
            r_state      <= ST_IDLE;
            r_cfg        <= '0;
            r_address    <= 32'd0;
            r_length     <= 32'd0;
            r_frame_done <= 1'b0;
            r_line       <= 16'd0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (i_wire_start) begin
                        r_cfg.base        <= i_wire_image_address;
                        r_cfg.stride      <= i_wire_image_stride;
                        r_cfg.width       <= i_wire_clip_width;
                        r_cfg.height      <= i_wire_clip_height;
                        r_cfg.pixel_bytes <= i_wire_pixel_bytes;
                        r_cfg.continuous  <= i_wire_continuous;
                        r_line            <= 16'd0;
                        if (i_wire_pixel_bytes == PB_ILLEGAL) begin
                            r_state <= ST_ERROR;
                        end else if (i_wire_clip_width == 16'd0 || i_wire_clip_height == 16'd0) begin
                            r_state      <= ST_DONE;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_address <= w_address;
                    r_length  <= w_length;
                    r_state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_fifo_ready) r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (i_wire_reader_error)     r_state <= ST_ERROR;
                    else if (i_wire_reader_done) r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_frame_end) begin
                        r_frame_done <= 1'b1;
                        if (r_cfg.continuous) begin
                            r_line  <= 16'd0;
                            r_state <= ST_CALC;
                        end else begin
                            r_line  <= r_line + 16'd1;
                            r_state <= ST_DONE;
                        end
                    end else begin
                        if (w_row_end) r_line <= r_line + 16'd1;
                        r_state <= ST_CALC;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Reader runs only in STREAM, so reset or any state exit drops it at once.
    assign o_wire_reader_resetn  = (r_state == ST_STREAM);
    assign o_wire_busy           = (r_state == ST_CALC) || (r_state == ST_WAIT) ||
                                   (r_state == ST_STREAM) || (r_state == ST_CHECK);
    assign o_wire_state          = r_state;
    assign o_wire_line           = r_line;
    assign o_wire_reader_address = r_address;
    assign o_wire_reader_length  = r_length;
    assign o_wire_frame_done     = r_frame_done;

endmodule

// File: tb/tb_painterengine_gpu_framereader.sv
// Directed bench for the frame reader: a table of single-frame configurations
// plus hand sequences for FIFO gating, error, continuous mode and async reset.
module tb_painterengine_gpu_framereader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic [31:0] img_addr = 32'd0;
    logic [15:0] stride = 16'd0;
    logic [15:0] width = 16'd0;
    logic [15:0] height = 16'd0;
    logic [1:0]  pbytes = 2'd0;
    logic [7:0]  fifo = 8'd128;
    logic [31:0] rd_addr;
    logic [31:0] rd_len;
    logic        rd_resetn;
    logic        rd_done = 1'b0;
    logic        rd_error = 1'b0;
    logic        frame_done;
    logic        busy;
    logic [2:0]  state;
    logic [15:0] line;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    painterengine_gpu_framereader dut (
        .i_wire_clock            (clk),
        .i_wire_reset            (rst),
        .i_wire_start            (start),
        .i_wire_continuous       (cont),
        .i_wire_image_address    (img_addr),
        .i_wire_image_stride     (stride),
        .i_wire_clip_width       (width),
        .i_wire_clip_height      (height),
        .i_wire_pixel_bytes      (pbytes),
        .i_wire_fifo_empty_count (fifo),
        .o_wire_reader_address   (rd_addr),
        .o_wire_reader_length    (rd_len),
        .o_wire_reader_resetn    (rd_resetn),
        .i_wire_reader_done      (rd_done),
        .i_wire_reader_error     (rd_error),
        .o_wire_frame_done       (frame_done),
        .o_wire_busy             (busy),
        .o_wire_state            (state),
        .o_wire_line             (line)
    );

    typedef struct {
        logic [15:0] w, h, s;
        logic [1:0]  pb;
        logic [31:0] base;
        int          nb;
        logic [31:0] fa, fl, la, ll;
        int          nfd;
        logic [2:0]  st;
        logic [15:0] ln;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic do_start(input logic [15:0] w, h, s, input logic [1:0] pb,
                            input logic [31:0] base, input logic c);
        width = w; height = h; stride = s; pbytes = pb; img_addr = base; cont = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (state == s) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic run_frame(output int nb, output logic [31:0] fa, fl, la, ll, output int nfd);
        nb = 0; nfd = 0; fa = 0; fl = 0; la = 0; ll = 0;
        for (int c = 0; c < 2000; c++) begin
            if (frame_done) nfd++;
            if (state == 3'd5 || state == 3'd7) break;
            if (state == 3'd3) begin
                if (nb == 0) begin fa = rd_addr; fl = rd_len; end
                la = rd_addr; ll = rd_len; nb++;
                rd_done = 1'b1;
                tick();
                rd_done = 1'b0;
            end else begin
                tick();
            end
        end
    endtask

    initial begin
        int          nb, nfd, bad, frames, bursts, busy_low;
        logic [31:0] fa, fl, la, ll;
        bit          ok;

        //          w    h    s    pb  base          nb fa            fl   la          ll   nfd st  ln
        vecs[0] = '{16'd100, 16'd2, 16'd128, 2'd2, 32'h1000, 4, 32'h1000, 32'd256, 32'h1300, 32'd144, 1, 3'd5, 16'd2};
        vecs[1] = '{16'd64,  16'd1, 16'd64,  2'd1, 32'h0,    1, 32'h0,    32'd128, 32'h0,    32'd128, 1, 3'd5, 16'd1};
        vecs[2] = '{16'd10,  16'd3, 16'd16,  2'd0, 32'h20,   3, 32'h20,   32'd10,  32'h40,   32'd10,  1, 3'd5, 16'd3};
        vecs[3] = '{16'd0,   16'd5, 16'd16,  2'd0, 32'h40,   0, 32'h0,    32'd0,   32'h0,    32'd0,   1, 3'd5, 16'd0};
        vecs[4] = '{16'd5,   16'd0, 16'd16,  2'd1, 32'h40,   0, 32'h0,    32'd0,   32'h0,    32'd0,   1, 3'd5, 16'd0};
        vecs[5] = '{16'd10,  16'd2, 16'd16,  2'd3, 32'h40,   0, 32'h0,    32'd0,   32'h0,    32'd0,   0, 3'd7, 16'd0};
        vecs[6] = '{16'd130, 16'd1, 16'd0,   2'd0, 32'hFFFFFFF0, 3, 32'hFFFFFFF0, 32'd64, 32'h70, 32'd2, 1, 3'd5, 16'd1};

        // reset state
        #3;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_resetn", 32'(rd_resetn), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_line", 32'(line), 32'd0);
        chk("rst_addr", rd_addr, 32'd0);
        chk("rst_len", rd_len, 32'd0);
        chk("rst_fdone", 32'(frame_done), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            do_start(vecs[i].w, vecs[i].h, vecs[i].s, vecs[i].pb, vecs[i].base, 1'b0);
            run_frame(nb, fa, fl, la, ll, nfd);
            chk($sformatf("v%0d_nbursts", i), 32'(nb), 32'(vecs[i].nb));
            chk($sformatf("v%0d_first_addr", i), fa, vecs[i].fa);
            chk($sformatf("v%0d_first_len", i), fl, vecs[i].fl);
            chk($sformatf("v%0d_last_addr", i), la, vecs[i].la);
            chk($sformatf("v%0d_last_len", i), ll, vecs[i].ll);
            chk($sformatf("v%0d_frame_done", i), 32'(nfd), 32'(vecs[i].nfd));
            chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("v%0d_line", i), 32'(line), 32'(vecs[i].ln));
            tick();
        end

        // FIFO gating: 63 free slots holds WAIT, 64 launches
        do_reset();
        fifo = 8'd63;
        do_start(16'd64, 16'd1, 16'd64, 2'd0, 32'h0, 1'b0);
        tick();
        chk("fifo_wait_entry", 32'(state), 32'd2);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (state !== 3'd2 || rd_resetn !== 1'b0) bad++;
        end
        chk("fifo_wait_hold", 32'(bad), 32'd0);
        fifo = 8'd64;
        tick();
        chk("fifo_stream_state", 32'(state), 32'd3);
        chk("fifo_stream_resetn", 32'(rd_resetn), 32'd1);
        chk("fifo_stream_len", rd_len, 32'd64);
        fifo = 8'd128;
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("fifo_check_resetn", 32'(rd_resetn), 32'd0);
        tick();
        chk("fifo_done_state", 32'(state), 32'd5);
        chk("fifo_done_pulse", 32'(frame_done), 32'd1);
        tick();
        chk("fifo_done_pulse_end", 32'(frame_done), 32'd0);

        // done and error together during burst 2: error wins
        do_reset();
        do_start(16'd100, 16'd2, 16'd128, 2'd2, 32'h1000, 1'b0);
        wait_state(3'd3, 50, ok);
        chk("err_wait_b1", 32'(ok), 32'd1);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        wait_state(3'd3, 50, ok);
        chk("err_wait_b2", 32'(ok), 32'd1);
        chk("err_b2_addr", rd_addr, 32'h1100);
        chk("err_b2_len", rd_len, 32'd144);
        rd_done = 1'b1; rd_error = 1'b1;
        tick();
        rd_done = 1'b0; rd_error = 1'b0;
        chk("err_state", 32'(state), 32'd7);
        chk("err_resetn", 32'(rd_resetn), 32'd0);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (frame_done !== 1'b0 || state !== 3'd7 || rd_addr !== 32'h1100 || rd_len !== 32'd144) bad++;
            tick();
        end
        chk("err_hold", 32'(bad), 32'd0);
        do_start(16'd100, 16'd2, 16'd128, 2'd2, 32'h1000, 1'b0);
        wait_state(3'd3, 50, ok);
        chk("err_restart_wait", 32'(ok), 32'd1);
        chk("err_restart_addr", rd_addr, 32'h1000);
        chk("err_restart_len", rd_len, 32'd256);

        // continuous mode: same burst every frame, busy never drops
        do_reset();
        do_start(16'd64, 16'd1, 16'd64, 2'd1, 32'h0, 1'b1);
        frames = 0; bursts = 0; bad = 0; busy_low = 0;
        for (int c = 0; c < 500 && frames < 3; c++) begin
            if (busy !== 1'b1) busy_low++;
            if (frame_done) frames++;
            if (state == 3'd3) begin
                bursts++;
                if (rd_addr !== 32'h0 || rd_len !== 32'd128) bad++;
                rd_done = 1'b1;
                tick();
                rd_done = 1'b0;
            end else begin
                tick();
            end
        end
        chk("cont_frames", 32'(frames), 32'd3);
        chk("cont_bursts", 32'(bursts), 32'd3);
        chk("cont_burst_vals", 32'(bad), 32'd0);
        chk("cont_busy_low", 32'(busy_low), 32'd0);

        // asynchronous reset mid-burst
        do_reset();
        do_start(16'd100, 16'd2, 16'd128, 2'd2, 32'h1000, 1'b0);
        wait_state(3'd3, 50, ok);
        chk("arst_wait", 32'(ok), 32'd1);
        chk("arst_pre_resetn", 32'(rd_resetn), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_resetn", 32'(rd_resetn), 32'd0);
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_addr", rd_addr, 32'd0);
        chk("arst_len", rd_len, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        tick();
        chk("arst_done_ignored", 32'(state), 32'd0);
        chk("arst_post_resetn", 32'(rd_resetn), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
